// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT output streamer.
// Frame geometry (NPT bins of DW bits each) and the bin unpack helper
// live here so the streamer and any sibling blocks agree on packing.
package fft_pkg;
  localparam int NPT   = 16;
  localparam int DW    = 16;
  localparam int IDX_W = $clog2(NPT);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

  // Bin k of a packed frame sits at [k*DW +: DW].
  function automatic logic [DW-1:0] bin_of(input logic [NPT*DW-1:0] frame,
                                           input logic [IDX_W-1:0]  k);
    return frame[k*DW +: DW];
  endfunction
endpackage

// File: rtl/fft_mag_approx.sv
// Alpha-max-beta-min magnitude estimate: max(|x|,|y|) + min(|x|,|y|)/2.
// Works in DW+1 bits so |-2^(DW-1)| = 2^(DW-1) does not wrap; the sum
// peaks at 3*2^(DW-2), which still fits in DW+1 bits.
module fft_mag_approx
  import fft_pkg::*;
(
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [DW:0]   mag
);
  logic [DW:0] sx, sy, ax, ay, mx, mn;

  // Sign-extend, take absolute values, order them and shift-add.
  always_comb begin
    sx  = {x[DW-1], x};
    sy  = {y[DW-1], y};
    ax  = sx[DW] ? (~sx + (DW+1)'(1)) : sx;
    ay  = sy[DW] ? (~sy + (DW+1)'(1)) : sy;
    mx  = (ax > ay) ? ax : ay;
    mn  = (ax > ay) ? ay : ax;
    mag = mx + (mn >> 1);
  end
endmodule

// File: rtl/fft_frame_streamer.sv
// Consumer end of the FFT output: waits LATENCY cycles after start, captures
// the packed real/imag frames, then streams the NPT bins in natural order
// over valid/ready.  Define FFT_STREAM_MAG_EN to add the out_mag port fed by
// an alpha-max-beta-min estimator on the current bin.
module fft_frame_streamer
  import fft_pkg::*;
#(
  parameter int LATENCY = 16
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [NPT*DW-1:0] x_frame,
  input  logic [NPT*DW-1:0] y_frame,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DW-1:0]     out_x,
  output logic [DW-1:0]     out_y,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
`ifdef FFT_STREAM_MAG_EN
  ,
  output logic [DW:0]       out_mag
`endif
);
  localparam int              LAT_W    = 8;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NPT - 1);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               cap;
  logic [NPT*DW-1:0]  xbuf, ybuf;
  logic               overrun_q;

  // State, latency counter and bin index registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: count down the FFT latency, capture, then walk the bins.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          cap     = 1'b1;
          state_d = STREAM;
          idx_d   = '0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame buffer: the only copy of the result once the FFT moves on.
  always_ff @(posedge clock) begin
    if (reset) begin
      xbuf <= '0;
      ybuf <= '0;
    end else if (cap) begin
      xbuf <= x_frame;
      ybuf <= y_frame;
    end
  end

  // Sticky flag for a start that arrived while a frame was in flight.
  always_ff @(posedge clock) begin
    if (reset)
      overrun_q <= 1'b0;
    else if (start && (state_q != IDLE))
      overrun_q <= 1'b1;
  end

  assign out_valid = (state_q == STREAM);
  assign out_x     = bin_of(xbuf, idx_q);
  assign out_y     = bin_of(ybuf, idx_q);
  assign out_index = idx_q;
  assign out_last  = out_valid && (idx_q == IDX_LAST);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

`ifdef FFT_STREAM_MAG_EN
  fft_mag_approx u_mag (
    .x   (out_x),
    .y   (out_y),
    .mag (out_mag)
  );
`endif
endmodule

// File: tb/tb_fft_frame_streamer.sv
// Scoreboard bench for fft_frame_streamer (LATENCY=4).  Stimulus pushes
// hand-computed beats into exp_q; the monitor pops on every handshake.
module tb_fft_frame_streamer;
  import fft_pkg::*;
  localparam int LAT = 4;

  logic              clock = 1'b0;
  logic              reset, start, out_ready;
  logic [NPT*DW-1:0] x_frame, y_frame;
  logic              out_valid, out_last, busy, overrun;
  logic [DW-1:0]     out_x, out_y;
  logic [IDX_W-1:0]  out_index;
`ifdef FFT_STREAM_MAG_EN
  logic [DW:0]       out_mag;
`endif

  typedef struct packed {
    logic [DW-1:0]    x;
    logic [DW-1:0]    y;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [DW:0]      mag;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int total = 0;
  int bad   = 0;

  logic             stall_q = 1'b0;
  logic [DW-1:0]    px, py;
  logic [IDX_W-1:0] pidx;

  fft_frame_streamer #(.LATENCY(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .x_frame   (x_frame),
    .y_frame   (y_frame),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun)
`ifdef FFT_STREAM_MAG_EN
    ,
    .out_mag   (out_mag)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input int k, input logic [DW:0] mag);
    beat_t b;
    b.x    = x;
    b.y    = y;
    b.idx  = IDX_W'(k);
    b.last = (k == NPT - 1);
    b.mag  = mag;
    exp_q.push_back(b);
  endtask

  task automatic set_all(input logic [DW-1:0] xv, input logic [DW-1:0] yv);
    for (int k = 0; k < NPT; k++) begin
      x_frame[k*DW +: DW] = xv;
      y_frame[k*DW +: DW] = yv;
    end
  endtask

  // Ramp frame: bin k = (k*0x100, -k); |x| dominates so mag = k*256 + k/2.
  task automatic ramp_frame();
    for (int k = 0; k < NPT; k++) begin
      x_frame[k*DW +: DW] = DW'(k * 256);
      y_frame[k*DW +: DW] = DW'(-k);
      push_exp(DW'(k * 256), DW'(-k), k, (DW+1)'(k * 256 + (k >> 1)));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    chk(nm, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin tick(); n++; end
    chk(nm, 32'(busy), 32'd0);
  endtask

  // Monitor: pops on each accepted beat, and checks hold during stalls.
  always @(negedge clock) begin
    if (!reset) begin
      if (stall_q) begin
        chk("valid_hold", 32'(out_valid), 32'd1);
        if (out_valid) begin
          chk("hold_x", 32'(out_x), 32'(px));
          chk("hold_y", 32'(out_y), 32'(py));
          chk("hold_idx", 32'(out_index), 32'(pidx));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_index), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_idx", 32'(out_index), 32'(e.idx));
          chk("beat_x", 32'(out_x), 32'(e.x));
          chk("beat_y", 32'(out_y), 32'(e.y));
          chk("beat_last", 32'(out_last), 32'(e.last));
`ifdef FFT_STREAM_MAG_EN
          chk("beat_mag", 32'(out_mag), 32'(e.mag));
`endif
        end
      end
      stall_q = out_valid && !out_ready;
      px      = out_x;
      py      = out_y;
      pidx    = out_index;
    end else begin
      stall_q = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    x_frame = '0; y_frame = '0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_x", 32'(out_x), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_idx", 32'(out_index), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    // start wins nothing against reset
    start = 1'b1; tick(); start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Basic stream: start in cycle 0, first valid in cycle 5, idle in 21.
    ramp_frame();
    pulse_start();
    chk("wait_busy", 32'(busy), 32'd1);
    for (int c = 1; c <= LAT; c++) begin
      chk("lat_valid_low", 32'(out_valid), 32'd0);
      tick();
    end
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_idx", 32'(out_index), 32'd0);
    for (int c = 0; c < NPT - 1; c++) tick();
    chk("last_flag", 32'(out_last), 32'd1);
    tick();
    chk("busy_fall", 32'(busy), 32'd0);
    chk("valid_fall", 32'(out_valid), 32'd0);
    chk("basic_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: ready pattern 1,0,0,1.
    ramp_frame();
    pulse_start();
    for (int i = 0; i < 200 && busy; i++) begin
      out_ready = ((i % 4) == 0) || ((i % 4) == 3);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Overrun: extra starts in WAIT and STREAM are dropped.
    chk("ovr_pre", 32'(overrun), 32'd0);
    ramp_frame();
    pulse_start();
    tick();
    pulse_start();
    chk("ovr_wait", 32'(overrun), 32'd1);
    wait_valid("ovr_stream_up");
    tick(); tick(); tick();
    pulse_start();
    wait_idle("ovr_idle");
    for (int i = 0; i < 10; i++) tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    chk("ovr_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream after index 6 accepted.
    ramp_frame();
    pulse_start();
    for (int n = 0; n < 100 && !(out_valid && out_index == IDX_W'(7)); n++) tick();
    chk("mid_idx7", 32'(out_index), 32'd7);
    chk("mid_pending", 32'(exp_q.size()), 32'd9);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    tick();
    ramp_frame();
    pulse_start();
    wait_valid("mid_restart_up");
    chk("mid_restart_idx", 32'(out_index), 32'd0);
    wait_idle("mid_restart_idle");
    chk("mid_drained", 32'(exp_q.size()), 32'd0);

    // Capture timing: change in cycle LAT is captured, in LAT+1 is not.
    set_all(16'h1111, 16'h1111);
    for (int k = 0; k < NPT; k++) push_exp(16'h2222, 16'h2222, k, 17'h03333);
    pulse_start();
    for (int c = 1; c < LAT; c++) tick();
    set_all(16'h2222, 16'h2222);
    wait_idle("cap_a_idle");
    chk("cap_a_drained", 32'(exp_q.size()), 32'd0);

    set_all(16'h1111, 16'h1111);
    for (int k = 0; k < NPT; k++) push_exp(16'h1111, 16'h1111, k, 17'h01999);
    pulse_start();
    for (int c = 1; c <= LAT; c++) tick();
    set_all(16'h2222, 16'h2222);
    wait_idle("cap_b_idle");
    chk("cap_b_drained", 32'(exp_q.size()), 32'd0);

`ifdef FFT_STREAM_MAG_EN
    // Magnitude corner cases: full-scale negative, and (300,-400) -> 550.
    set_all(16'h0000, 16'h0000);
    x_frame[0*DW +: DW] = 16'h8000;
    x_frame[1*DW +: DW] = 16'd300;
    y_frame[1*DW +: DW] = 16'hFE70;
    push_exp(16'h8000, 16'h0000, 0, 17'h08000);
    push_exp(16'd300, 16'hFE70, 1, 17'd550);
    for (int k = 2; k < NPT; k++) push_exp(16'h0000, 16'h0000, k, 17'h0);
    pulse_start();
    wait_idle("mag_idle");
    chk("mag_drained", 32'(exp_q.size()), 32'd0);
`endif

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
